// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks an edge list, fetches both endpoint coordinates
// from a shared X/Y position memory and accumulates Manhattan wirelength
// statistics (plain cost, one-hop cost, longest edge, count of illegal edges).
// Every edge costs exactly six cycles: E_RD, E_CAP, A_CAP, B_CAP, CALC, ACC.
module placement_cost_eval #(
    parameter int N_EDGE  = 37,
    parameter int GRID_N  = 6,
    parameter int EADDR_W = 7,
    parameter int PADDR_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               edge_re,
    output logic [EADDR_W-1:0] edge_addr,
    input  logic [31:0]        edge_a,
    input  logic [31:0]        edge_b,
    output logic               pos_re,
    output logic [PADDR_W-1:0] pos_addr,
    input  logic signed [31:0] pos_x,
    input  logic signed [31:0] pos_y,
    output logic signed [31:0] cost_sum,
    output logic signed [31:0] cost_1hop,
    output logic [31:0]        max_len,
    output logic [31:0]        bad_cnt,
    output logic [31:0]        cycles
);

    typedef enum logic [2:0] {
        IDLE,
        E_RD,
        E_CAP,
        A_CAP,
        B_CAP,
        CALC,
        ACC,
        DONE
    } state_t;

    localparam logic [EADDR_W-1:0] LAST_IDX = EADDR_W'(N_EDGE - 1);
    localparam logic signed [31:0] GRID_LIM = 32'(GRID_N);
    localparam bit                 NO_EDGES = (N_EDGE == 0);

    state_t             state;
    logic [EADDR_W-1:0] idx;
    logic [PADDR_W-1:0] b_node;
    logic signed [31:0] xa;
    logic signed [31:0] ya;
    logic signed [31:0] xb;
    logic signed [31:0] yb;
    logic [31:0]        dx;
    logic [31:0]        dy;
    logic               edge_ok;

    logic signed [31:0] diff_x;
    logic signed [31:0] diff_y;
    logic [31:0]        abs_x;
    logic [31:0]        abs_y;
    logic [31:0]        len;
    logic [31:0]        hop;

    // Node ids wider than the position memory are simply truncated.
    logic unused_id_bits;
    assign unused_id_bits = ^{edge_a[31:PADDR_W], edge_b[31:PADDR_W]};

    // A coordinate is legal only inside 0..GRID_N-1; -1 (unplaced) fails the first test.
    function automatic logic on_grid(input logic signed [31:0] v);
        return (v >= 32'sd0) && (v < GRID_LIM);
    endfunction

    // The source node id is forwarded straight from the edge memory in E_CAP,
    // since it only becomes valid that cycle; the sink id is held in b_node for A_CAP.
    assign pos_addr = (state == E_CAP) ? edge_a[PADDR_W-1:0] : b_node;

    // Absolute coordinate differences and per-edge cost terms.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        diff_x = xa - xb;
        diff_y = ya - yb;
        abs_x  = diff_x[31] ? 32'(-diff_x) : 32'(diff_x);
        abs_y  = diff_y[31] ? 32'(-diff_y) : 32'(diff_y);
        len    = dx + dy;
        hop    = (dx >> 1) + {31'd0, dx[0]} + (dy >> 1) + {31'd0, dy[0]} - 32'd1;
    end

    // Control FSM with registered outputs and the accumulation datapath.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            edge_re   <= 1'b0;
            edge_addr <= '0;
            pos_re    <= 1'b0;
            b_node    <= '0;
            idx       <= '0;
            xa        <= '0;
            ya        <= '0;
            xb        <= '0;
            yb        <= '0;
            dx        <= '0;
            dy        <= '0;
            edge_ok   <= 1'b0;
            cost_sum  <= '0;
            cost_1hop <= '0;
            max_len   <= '0;
            bad_cnt   <= '0;
            cycles    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cost_sum  <= '0;
                        cost_1hop <= '0;
                        max_len   <= '0;
                        bad_cnt   <= '0;
                        idx       <= '0;
                        // The acceptance cycle itself counts as the first cycle,
                        // so cycles reads 6*N_EDGE+1 while done is high.
                        cycles    <= 32'd1;
                        busy      <= 1'b1;
                        if (NO_EDGES) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= E_RD;
                            edge_re   <= 1'b1;
                            edge_addr <= '0;
                        end
                    end
                end
                E_RD: begin
                    edge_re <= 1'b0;
                    pos_re  <= 1'b1;
                    cycles  <= cycles + 32'd1;
                    state   <= E_CAP;
                end
                E_CAP: begin
                    b_node <= edge_b[PADDR_W-1:0];
                    cycles <= cycles + 32'd1;
                    state  <= A_CAP;
                end
                A_CAP: begin
                    xa     <= pos_x;
                    ya     <= pos_y;
                    pos_re <= 1'b0;
                    cycles <= cycles + 32'd1;
                    state  <= B_CAP;
                end
                B_CAP: begin
                    xb     <= pos_x;
                    yb     <= pos_y;
                    cycles <= cycles + 32'd1;
                    state  <= CALC;
                end
                CALC: begin
                    dx      <= abs_x;
                    dy      <= abs_y;
                    edge_ok <= on_grid(xa) && on_grid(ya) && on_grid(xb) && on_grid(yb);
                    cycles  <= cycles + 32'd1;
                    state   <= ACC;
                end
                ACC: begin
                    if (edge_ok) begin
                        cost_sum  <= cost_sum + len - 32'd1;
                        cost_1hop <= cost_1hop + hop;
                        if (len > max_len) begin
                            max_len <= len;
                        end
                    end else begin
                        bad_cnt <= bad_cnt + 32'd1;
                    end
                    cycles <= cycles + 32'd1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx       <= idx + 1'b1;
                        edge_addr <= idx + 1'b1;
                        edge_re   <= 1'b1;
                        state     <= E_RD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed bench for placement_cost_eval: three instances (1, 2 and 5 edges)
// share one position memory; each has its own edge memory. Expected values
// are hand-computed from the node coordinates listed below.
module tb_placement_cost_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               start     [3];
    logic               busy      [3];
    logic               done      [3];
    logic               edge_re   [3];
    logic [6:0]         edge_addr [3];
    logic [31:0]        edge_a    [3];
    logic [31:0]        edge_b    [3];
    logic               pos_re    [3];
    logic [6:0]         pos_addr  [3];
    logic signed [31:0] pos_x     [3];
    logic signed [31:0] pos_y     [3];
    logic signed [31:0] cost_sum  [3];
    logic signed [31:0] cost_1hop [3];
    logic [31:0]        max_len   [3];
    logic [31:0]        bad_cnt   [3];
    logic [31:0]        cycles    [3];

    logic [31:0]        mem_a  [3][128];
    logic [31:0]        mem_b  [3][128];
    logic signed [31:0] px_mem [128];
    logic signed [31:0] py_mem [128];

    int done_cnt [3] = '{0, 0, 0};
    int total = 0;
    int bad   = 0;

    placement_cost_eval #(.N_EDGE(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .edge_re(edge_re[0]), .edge_addr(edge_addr[0]), .edge_a(edge_a[0]), .edge_b(edge_b[0]),
        .pos_re(pos_re[0]), .pos_addr(pos_addr[0]), .pos_x(pos_x[0]), .pos_y(pos_y[0]),
        .cost_sum(cost_sum[0]), .cost_1hop(cost_1hop[0]), .max_len(max_len[0]),
        .bad_cnt(bad_cnt[0]), .cycles(cycles[0])
    );

    placement_cost_eval #(.N_EDGE(2)) u_d2 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .edge_re(edge_re[1]), .edge_addr(edge_addr[1]), .edge_a(edge_a[1]), .edge_b(edge_b[1]),
        .pos_re(pos_re[1]), .pos_addr(pos_addr[1]), .pos_x(pos_x[1]), .pos_y(pos_y[1]),
        .cost_sum(cost_sum[1]), .cost_1hop(cost_1hop[1]), .max_len(max_len[1]),
        .bad_cnt(bad_cnt[1]), .cycles(cycles[1])
    );

    placement_cost_eval #(.N_EDGE(5)) u_d5 (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .edge_re(edge_re[2]), .edge_addr(edge_addr[2]), .edge_a(edge_a[2]), .edge_b(edge_b[2]),
        .pos_re(pos_re[2]), .pos_addr(pos_addr[2]), .pos_x(pos_x[2]), .pos_y(pos_y[2]),
        .cost_sum(cost_sum[2]), .cost_1hop(cost_1hop[2]), .max_len(max_len[2]),
        .bad_cnt(bad_cnt[2]), .cycles(cycles[2])
    );

    // Synchronous-read memories: data appears the cycle after the read enable.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (edge_re[g]) begin
                edge_a[g] <= mem_a[g][edge_addr[g]];
                edge_b[g] <= mem_b[g][edge_addr[g]];
            end
            if (pos_re[g]) begin
                pos_x[g] <= px_mem[pos_addr[g]];
                pos_y[g] <= py_mem[pos_addr[g]];
            end
        end
    end

    // Count done pulses per instance.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_res(input int id, input string pfx, input int s, input int h,
                             input int m, input int b, input int c);
        check({pfx, "_cost_sum"}, cost_sum[id], s);
        check({pfx, "_cost_1hop"}, cost_1hop[id], h);
        check({pfx, "_max_len"}, max_len[id], m);
        check({pfx, "_bad_cnt"}, bad_cnt[id], b);
        check({pfx, "_cycles"}, cycles[id], c);
    endtask

    // Start one evaluation; optionally pulse start again at cycle poke_at or
    // assert reset at cycle rst_at. lat is the cycle index (acceptance = 0)
    // at which done was seen.
    task automatic run(input int id, input int poke_at, input int rst_at,
                       output int lat, output bit got_done);
        got_done = 1'b0;
        @(negedge clk) start[id] = 1'b1;
        @(negedge clk) start[id] = 1'b0;
        lat = 1;
        while (!done[id] && lat < 400) begin
            start[id] = (lat == poke_at);
            if (lat == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            lat++;
        end
        start[id] = 1'b0;
        got_done = done[id];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit gd;
        int snap;

        reset = 1'b1;
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        for (int i = 0; i < 128; i++) begin
            px_mem[i] = 0;
            py_mem[i] = 0;
            for (int g = 0; g < 3; g++) begin
                mem_a[g][i] = 0;
                mem_b[g][i] = 0;
            end
        end
        // Node coordinates.
        px_mem[0] = 0;  py_mem[0] = 0;
        px_mem[1] = 3;  py_mem[1] = 2;
        px_mem[2] = 1;  py_mem[2] = 1;
        px_mem[3] = 1;  py_mem[3] = 2;
        px_mem[4] = 5;  py_mem[4] = 5;
        px_mem[5] = -1; py_mem[5] = -1;
        px_mem[6] = 6;  py_mem[6] = 0;
        px_mem[7] = 2;  py_mem[7] = 4;
        px_mem[8] = 4;  py_mem[8] = 1;
        // d1: (0,0)-(3,2)
        mem_a[0][0] = 0; mem_b[0][0] = 1;
        // d2: (1,1)-(1,2), (0,0)-(5,5)
        mem_a[1][0] = 2; mem_b[1][0] = 3;
        mem_a[1][1] = 0; mem_b[1][1] = 4;
        // d5: legal, unplaced, legal (reversed deltas), off-grid x=6, legal
        mem_a[2][0] = 0; mem_b[2][0] = 1;
        mem_a[2][1] = 5; mem_b[2][1] = 2;
        mem_a[2][2] = 7; mem_b[2][2] = 8;
        mem_a[2][3] = 6; mem_b[2][3] = 3;
        mem_a[2][4] = 2; mem_b[2][4] = 4;

        repeat (3) @(negedge clk);
        check("rst_busy", busy[2], 0);
        check("rst_done", done[2], 0);
        check("rst_edge_re", edge_re[2], 0);
        check("rst_pos_re", pos_re[2], 0);
        check("rst_addr", {edge_addr[2], pos_addr[2]}, 0);
        check_res(2, "rst", 0, 0, 0, 0, 0);

        // Reset wins over start.
        start[2] = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", busy[2], 0);
        reset = 1'b0;
        start[2] = 1'b0;
        @(negedge clk);

        // Single edge (0,0)-(3,2).
        run(0, -1, -1, lat, gd);
        check("d1_done_seen", gd, 1);
        check("d1_latency", lat, 7);
        check_res(0, "d1", 4, 2, 5, 0, 7);
        @(negedge clk);
        check("d1_done_pulse", done[0], 0);
        check("d1_idle_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        check("d1_hold_sum", cost_sum[0], 4);
        check("d1_hold_cycles", cycles[0], 7);

        // Two edges.
        run(1, -1, -1, lat, gd);
        check("d2_done_seen", gd, 1);
        check("d2_latency", lat, 13);
        check_res(1, "d2", 9, 5, 10, 0, 13);

        // Five edges with one unplaced and one off-grid endpoint.
        run(2, -1, -1, lat, gd);
        check("d5_done_seen", gd, 1);
        check("d5_latency", lat, 31);
        check_res(2, "d5", 15, 7, 8, 2, 31);

        // Start pulse mid-run is ignored.
        repeat (2) @(negedge clk);
        snap = done_cnt[2];
        run(2, 10, -1, lat, gd);
        check("poke_done_seen", gd, 1);
        check("poke_latency", lat, 31);
        check_res(2, "poke", 15, 7, 8, 2, 31);
        repeat (40) @(negedge clk);
        check("poke_done_count", done_cnt[2] - snap, 1);
        check("poke_idle", busy[2], 0);

        // Reset during B_CAP of edge 3 (cycle 22) aborts without done.
        snap = done_cnt[2];
        run(2, -1, 22, lat, gd);
        check("abort_busy", busy[2], 0);
        check("abort_done", done[2], 0);
        check("abort_re", {edge_re[2], pos_re[2]}, 0);
        check("abort_addr", {edge_addr[2], pos_addr[2]}, 0);
        check_res(2, "abort", 0, 0, 0, 0, 0);
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt[2] - snap, 0);
        run(2, -1, -1, lat, gd);
        check("rerun_done_seen", gd, 1);
        check_res(2, "rerun", 15, 7, 8, 2, 31);

        // Start held high through DONE is accepted in the following IDLE cycle.
        @(negedge clk) start[0] = 1'b1;
        lat = 0;
        while (!done[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_done_seen", done[0], 1);
        @(negedge clk);
        check("hold_idle_busy", busy[0], 0);
        @(negedge clk);
        start[0] = 1'b0;
        check("hold_restart_busy", busy[0], 1);
        lat = 0;
        while (!done[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_second_done", done[0], 1);
        check_res(0, "hold", 4, 2, 5, 0, 7);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
